popcount_pattern_gen: RTL and testbench



---
 rtl/popgen_pkg.sv | 23 ++
 rtl/lsb_index.sv | 18 +
 rtl/popcount_pattern_gen.sv | 165 ++++++++++++++++
 tb/tb_popcount_pattern_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/popgen_pkg.sv
// Shared types and helpers for the popcount pattern generator.
// Holds the FSM state enum, last-word helper and sequence counter width.
package popgen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SEQ_CNT_W = 16;

  // Highest word of a given weight: all ones packed at the top.
  function automatic logic [31:0] last_word(
    input logic [31:0] weight,
    input logic [31:0] width
  );
    logic [31:0] m;
    m = (32'd1 << weight) - 32'd1;
    return m << (width - weight);
  endfunction

endpackage

// File: rtl/lsb_index.sv
// Trailing-zero counter: tz = index of lowest set bit, WIDTH when x == 0.
// Ports: x [WIDTH-1:0] in, tz [TW-1:0] out (combinational).
module lsb_index #(
  parameter int WIDTH = 15,
  parameter int TW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] x,
  output logic [TW-1:0]    tz
);

  always_comb begin
    tz = TW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) tz = TW'(i);
    end
  end

endmodule

// File: rtl/popcount_pattern_gen.sv
// Enumerates all WIDTH-bit words of a given popcount, ascending, over valid/ready.
// Ports: clk, rst_n, start, weight -> busy, out_valid/out_ready, out_word,
// out_last, done, err; seq_cnt only when POPGEN_SEQ_CNT_EN is defined.
module popcount_pattern_gen
  import popgen_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    weight,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_last,
  output logic             done,
  output logic             err
`ifdef POPGEN_SEQ_CNT_EN
  ,
  output logic [SEQ_CNT_W-1:0] seq_cnt
`endif
);

  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
  localparam logic [CW:0]    TWO = (CW + 1)'(2);

  state_t state_q, state_d;

  logic [WIDTH-1:0] x_q, x_d;
  logic [CW-1:0]    wt_q, wt_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CW-1:0]    tz;
  logic [WIDTH:0]   xe, c, r, nx, mask;
  logic [31:0]      lw_new, lw_run;
  logic             weight_ok;
  logic             accept;

  lsb_index #(
    .WIDTH(WIDTH),
    .TW   (CW)
  ) u_lsb (
    .x (x_q),
    .tz(tz)
  );

  assign weight_ok = 32'(weight) <= 32'(WIDTH);
  assign accept    = (state_q == IDLE) && start && weight_ok;
  assign lw_new    = last_word(32'(weight), 32'(WIDTH));
  assign lw_run    = last_word(32'(wt_q), 32'(WIDTH));

  // Gosper successor with one spare bit; the divide by c is a shift by tz.
  always_comb begin
    xe   = {1'b0, x_q};
    c    = xe & (~xe + ONE);
    r    = xe + c;
    nx   = r | ((r ^ xe) >> ({1'b0, tz} + TWO));
    mask = (ONE << weight) - ONE;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    wt_d    = wt_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (weight_ok) begin
            state_d = RUN;
            x_d     = mask[WIDTH-1:0];
            wt_d    = weight;
            last_d  = 32'(mask) == lw_new;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = DONE;
            x_d     = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d    = nx[WIDTH-1:0];
            last_d = 32'(nx) == lw_run;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        last_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      wt_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      wt_q    <= wt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_word  = x_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef POPGEN_SEQ_CNT_EN
  logic [SEQ_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (valid_q && out_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign seq_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Self-checking bench for popcount_pattern_gen (WIDTH=15 and WIDTH=6).
// Reference sequences come from brute-force filtering of all words by popcount.
module tb_popcount_pattern_gen;

  localparam int W   = 15;
  localparam int CW  = 4;
  localparam int W6  = 6;
  localparam int CW6 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [CW-1:0] weight;
  logic          busy, out_valid, out_ready, out_last, done, err;
  logic [W-1:0]  out_word;

  logic           start6;
  logic [CW6-1:0] weight6;
  logic           busy6, valid6, last6, done6, err6;
  logic           ready6 = 1'b1;
  logic [W6-1:0]  word6;

`ifdef POPGEN_SEQ_CNT_EN
  logic [15:0] seq_cnt, seq_cnt6;
`endif

  popcount_pattern_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .weight   (weight),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_last (out_last),
    .done     (done),
    .err      (err)
`ifdef POPGEN_SEQ_CNT_EN
    ,
    .seq_cnt  (seq_cnt)
`endif
  );

  popcount_pattern_gen #(.WIDTH(W6)) dut6 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start6),
    .weight   (weight6),
    .busy     (busy6),
    .out_valid(valid6),
    .out_ready(ready6),
    .out_word (word6),
    .out_last (last6),
    .done     (done6),
    .err      (err6)
`ifdef POPGEN_SEQ_CNT_EN
    ,
    .seq_cnt  (seq_cnt6)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input int w, input int width);
    exp_q.delete();
    for (int v = 0; v < (1 << width); v++) begin
      if ($countones(v) == w) exp_q.push_back(32'(v));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int w, input bit rnd, input int inject_at);
    int idx;
    int cyc;
    logic stalled;
    logic [W-1:0] pw;
    logic pl;
    build(w, W);
    weight = CW'(w);
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    chk("valid_latency", 32'(out_valid), 1);
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    pw = '0;
    pl = 1'b0;
    while (idx < exp_q.size() && cyc < 20000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("stall_word", 32'(out_word), 32'(pw));
        chk("stall_last", 32'(out_last), 32'(pl));
      end
      chk("valid_held", 32'(out_valid), 1);
      if (out_ready) begin
        chk("word", 32'(out_word), exp_q[idx]);
        chk("last", 32'(out_last), 32'(idx == exp_q.size() - 1));
        chk("popcnt", 32'($countones(out_word)), 32'(w));
        idx++;
      end
      stalled = !out_ready;
      pw = out_word;
      pl = out_last;
      if (idx == inject_at) begin
        start  = 1'b1;
        weight = CW'(3);
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    chk("no_timeout", 32'(cyc < 20000), 1);
    start = 1'b0;
    out_ready = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("valid_drop", 32'(out_valid), 0);
    chk("busy_in_done", 32'(busy), 1);
    step();
    chk("done_clear", 32'(done), 0);
    chk("busy_fall", 32'(busy), 0);
`ifdef POPGEN_SEQ_CNT_EN
    chk("seq_cnt", 32'(seq_cnt), 32'(exp_q.size()));
`endif
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    weight = '0;
    out_ready = 1'b0;
    start6 = 1'b0;
    weight6 = '0;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_word", 32'(out_word), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst6_busy", 32'(busy6), 0);
    chk("rst6_err", 32'(err6), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run(2, 1'b0, -1);
    run(0, 1'b0, -1);
    run(15, 1'b0, -1);
    run(7, 1'b1, -1);
    run(2, 1'b0, 5);

    weight6 = CW6'(7);
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    chk("err_pulse", 32'(err6), 1);
    chk("err_valid", 32'(valid6), 0);
    chk("err_busy", 32'(busy6), 0);
    step();
    chk("err_clear", 32'(err6), 0);
    chk("err_valid2", 32'(valid6), 0);
    chk("err_busy2", 32'(busy6), 0);

    build(4, W);
    weight = CW'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("w4_word", 32'(out_word), exp_q[k]);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_word", 32'(out_word), 0);
    chk("arst_last", 32'(out_last), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    step();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_busy", 32'(busy), 0);
    weight = CW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("w1_first", 32'(out_word), 32'h1);
    step();
    chk("w1_stall", 32'(out_word), 32'h1);
    run_tail();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Drains the weight-1 sequence started directly above with full readiness.
  task automatic run_tail();
    int idx;
    int cyc;
    build(1, W);
    idx = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (idx < exp_q.size() && cyc < 1000) begin
      chk("w1_word", 32'(out_word), exp_q[idx]);
      chk("w1_last", 32'(out_last), 32'(idx == exp_q.size() - 1));
      idx++;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("w1_done", 32'(done), 1);
  endtask

endmodule
